sha_message_block_loader: RTL

Assembles the serial 32-bit message word stream into complete 16-word SHA-256 message blocks, double-buffered, and presents each block to `sha_message_expander_pipeline` as its `W_i` history vector. It sits directly upstream of the expander. It converts a one-word-per-cycle valid/ready stream into a one-block valid/ready handoff, so the next block loads while the current block is held or consumed.

---
 rtl/sha_pkg.sv | 7 +
 rtl/sha_block_slot.sv | 31 +++
 rtl/sha_message_block_loader.sv | 56 +++++
 3 files changed

// File: rtl/sha_pkg.sv
// sha_pkg: shared SHA-256 word and block types
package sha_pkg;
  localparam int WORD_WIDTH = 32;
  localparam int BLOCK_WORDS = 16;
  typedef logic [31:0] sha_word_t;
  typedef logic [15:0][31:0] sha_block_t;
endpackage

// File: rtl/sha_block_slot.sv
// sha_block_slot: one 16-word block buffer with full and first-of-message flags
module sha_block_slot
  import sha_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [3:0] wr_idx,
  input  sha_word_t  wr_data,
  input  logic       first_in,
  input  logic       set_full,
  input  logic       clr_full,
  output sha_block_t data,
  output logic       full,
  output logic       first
);
  // word storage; the word landing at index 15 opens a block and latches its first flag
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      data <= '0;
      first <= 1'b0;
    end else if (wr_en) begin
      data[wr_idx] <= wr_data;
      if (wr_idx == 4'd15) first <= first_in;
    end
  // occupancy flag; set and clear never target the same slot in one cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) full <= 1'b0;
    else if (set_full) full <= 1'b1;
    else if (clr_full) full <= 1'b0;
endmodule

// File: rtl/sha_message_block_loader.sv
// sha_message_block_loader: packs a 32-bit word stream into double-buffered 16-word SHA-256 blocks
module sha_message_block_loader #(
  parameter int WORD_WIDTH = sha_pkg::WORD_WIDTH,
  parameter int BLOCK_WORDS = sha_pkg::BLOCK_WORDS
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  word_valid_i,
  output logic                                  word_ready_o,
  input  logic [WORD_WIDTH-1:0]                 word_i,
  input  logic                                  msg_start_i,
  output logic                                  block_valid_o,
  input  logic                                  block_ready_i,
  output logic [BLOCK_WORDS-1:0][WORD_WIDTH-1:0] block_o,
  output logic                                  block_first_o
);
  import sha_pkg::*;
  logic       fill_sel, rd_sel, word_acc, blk_acc, done;
  logic [3:0] wcnt, k;
  logic [1:0] full, first;
  sha_block_t data [2];
  assign word_ready_o = !full[fill_sel];
  assign block_valid_o = full[rd_sel];
  assign block_o = data[rd_sel];
  assign block_first_o = first[rd_sel];
  assign word_acc = word_valid_i && word_ready_o;
  assign blk_acc = block_valid_o && block_ready_i;
  assign k = (msg_start_i && wcnt != 4'd0) ? 4'd0 : wcnt;
  assign done = word_acc && k == 4'd15;
  // word counter wraps to 0 after word 15; fill and read pointers ping-pong between slots
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wcnt <= 4'd0;
      fill_sel <= 1'b0;
      rd_sel <= 1'b0;
    end else begin
      if (word_acc) wcnt <= k + 4'd1;
      if (done) fill_sel <= !fill_sel;
      if (blk_acc) rd_sel <= !rd_sel;
    end
  for (genvar i = 0; i < 2; i++) begin : g_slot
    sha_block_slot u_slot (
      .clk(clk),
      .rst_n(rst_n),
      .wr_en(word_acc && fill_sel == 1'(i)),
      .wr_idx(4'd15 - k),
      .wr_data(word_i),
      .first_in(msg_start_i),
      .set_full(done && fill_sel == 1'(i)),
      .clr_full(blk_acc && rd_sel == 1'(i)),
      .data(data[i]),
      .full(full[i]),
      .first(first[i])
    );
  end
endmodule
